spi_host_master: RTL

- SPI master that drives the MiST-style controller bus from the host side: SCK, MOSI (into the core's SPI_DI) and the three active-low selects (user_io CONF_DATA0, data_io SS2, OSD SS3).
- Samples MISO (the core's SPI_DO).
- Used by the DeMiSTify control CPU to talk to a core's user_io/data_io/OSD slaves.
- Byte-wide request/response interface, SPI mode 0, MSB first.

---
 rtl/spi_host_master.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/spi_host_master.sv
// SPI mode-0 host master for the MiST controller bus: one byte per request, MSB first,
// with three mutually exclusive active-low selects and a select-to-SCK setup guard.
module spi_host_master #(
    parameter int CLKDIV   = 4,
    parameter int CS_SETUP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cs_sel,
    input  logic       cs_en,
    input  logic [7:0] tx_data,
    input  logic       tx_req,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_conf_data0_n,
    output logic       spi_ss2_n,
    output logic       spi_ss3_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t     state, state_next;
    logic [7:0] div, div_next;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic [7:0] tx_shift, tx_shift_next;
    logic [7:0] rx_shift, rx_shift_next;
    logic [7:0] guard, guard_next;
    logic [2:0] sel, sel_next, sel_dec;
    logic       sck_next, mosi_next, rx_valid_next;
    logic [7:0] rx_data_next;
    logic [1:0] miso_sync;

    // Select vector ordering is {conf_data0_n, ss2_n, ss3_n}.
    always_comb begin
        sel_dec = 3'b111;
        if (cs_en) begin
            case (cs_sel)
                2'd1:    sel_dec = 3'b011;
                2'd2:    sel_dec = 3'b101;
                2'd3:    sel_dec = 3'b110;
                default: sel_dec = 3'b111;
            endcase
        end
    end

    assign {spi_conf_data0_n, spi_ss2_n, spi_ss3_n} = sel;
    assign busy = (state == LOW) || (state == HIGH);

    always_comb begin
        state_next    = state;
        div_next      = div;
        bit_cnt_next  = bit_cnt;
        tx_shift_next = tx_shift;
        rx_shift_next = rx_shift;
        guard_next    = guard;
        sel_next      = sel;
        sck_next      = spi_sck;
        mosi_next     = spi_mosi;
        rx_valid_next = 1'b0;
        rx_data_next  = rx_data;

        case (state)
            IDLE: begin
                sck_next  = 1'b0;
                mosi_next = 1'b0;
                // A select change blocks starts until the guard has fully run down.
                if (sel_dec != sel) begin
                    sel_next   = sel_dec;
                    guard_next = 8'(CS_SETUP);
                end else begin
                    if (guard != 8'd0)
                        guard_next = guard - 8'd1;
                    if (tx_req && guard == 8'd0) begin
                        tx_shift_next = tx_data;
                        mosi_next     = tx_data[7];
                        div_next      = 8'd0;
                        bit_cnt_next  = 3'd0;
                        state_next    = LOW;
                    end
                end
            end
            LOW: begin
                if (div == 8'(CLKDIV - 1)) begin
                    div_next   = 8'd0;
                    sck_next   = 1'b1;
                    state_next = HIGH;
                end else begin
                    div_next = div + 8'd1;
                end
            end
            HIGH: begin
                if (div == 8'(CLKDIV - 1)) begin
                    div_next      = 8'd0;
                    sck_next      = 1'b0;
                    rx_shift_next = {rx_shift[6:0], miso_sync[1]};
                    if (bit_cnt == 3'd7) begin
                        rx_data_next  = {rx_shift[6:0], miso_sync[1]};
                        rx_valid_next = 1'b1;
                        mosi_next     = 1'b0;
                        state_next    = DONE;
                    end else begin
                        bit_cnt_next  = bit_cnt + 3'd1;
                        tx_shift_next = {tx_shift[6:0], 1'b0};
                        mosi_next     = tx_shift[6];
                        state_next    = LOW;
                    end
                end else begin
                    div_next = div + 8'd1;
                end
            end
            DONE: begin
                mosi_next  = 1'b0;
                state_next = IDLE;
                // The select is frozen here, so a chained request skips straight to LOW.
                if (tx_req && guard == 8'd0) begin
                    tx_shift_next = tx_data;
                    mosi_next     = tx_data[7];
                    div_next      = 8'd0;
                    bit_cnt_next  = 3'd0;
                    state_next    = LOW;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            div       <= 8'd0;
            bit_cnt   <= 3'd0;
            tx_shift  <= 8'd0;
            rx_shift  <= 8'd0;
            guard     <= 8'd0;
            sel       <= 3'b111;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'd0;
            miso_sync <= 2'b00;
        end else begin
            state     <= state_next;
            div       <= div_next;
            bit_cnt   <= bit_cnt_next;
            tx_shift  <= tx_shift_next;
            rx_shift  <= rx_shift_next;
            guard     <= guard_next;
            sel       <= sel_next;
            spi_sck   <= sck_next;
            spi_mosi  <= mosi_next;
            rx_valid  <= rx_valid_next;
            rx_data   <= rx_data_next;
            miso_sync <= {miso_sync[0], spi_miso};
        end
    end

endmodule
